// File: rtl/axi_extraction_regs_pkg.sv
// rtl/axi_extraction_regs_pkg.sv - shared constants for the extraction register block
package axi_extraction_pkg;

    localparam int CNT_W = 32;

    localparam logic [3:0] ADDR_CTRL = 4'h0;
    localparam logic [3:0] ADDR_KEY  = 4'h4;
    localparam logic [3:0] ADDR_HIT  = 4'h8;
    localparam logic [3:0] ADDR_DROP = 4'hC;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Counter registers are status only; host writes to them are rejected
    function automatic logic reg_is_ro(input logic [3:0] offset);
        return (offset == ADDR_HIT) || (offset == ADDR_DROP);
    endfunction

endpackage

// File: rtl/axi_extraction_regs_if.sv
// rtl/axi_extraction_regs_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi_extraction_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/sat_event_counter.sv
// rtl/sat_event_counter.sv - saturating event counter, clear beats increment
module sat_event_counter
    import axi_extraction_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear first, otherwise count enabled events until all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && inc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/axi_extraction_regs.sv
// rtl/axi_extraction_regs.sv - AXI4-Lite control/status registers for the extraction pipeline
module axi_extraction_regs
    import axi_extraction_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    axi_extraction_regs_if.slave          s_axi,
    output logic                          extract_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0] extract_key,
    input  logic                          hit_pulse,
    input  logic                          drop_pulse
);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic                          awready_q, awready_d;
    logic                          bvalid_q,  bvalid_d;
    logic [1:0]                    bresp_q,   bresp_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q,  rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                          en_q,      en_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] key_q,     key_d;

    logic             wr_en;
    logic             rd_en;
    logic             cnt_clr;
    logic [3:0]       wr_off;
    logic [3:0]       rd_off;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             unused_bits;

    // Word-aligned offsets; byte lanes and protection bits carry no meaning here
    assign wr_off      = {s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign rd_off      = {s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign unused_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                           s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    // AWREADY doubles as WREADY, so a handshake needs both valids during the ready pulse
    assign wr_en = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign rd_en = arready_q & s_axi.S_AXI_ARVALID;

    // Next-state for both channels and the writable registers
    always_comb begin
        awready_d = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & !bvalid_q & !awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = reg_is_ro(wr_off) ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        en_d    = en_q;
        key_d   = key_q;
        cnt_clr = 1'b0;
        if (wr_en && wr_off == ADDR_CTRL && s_axi.S_AXI_WSTRB[0]) begin
            en_d    = s_axi.S_AXI_WDATA[CTRL_EN_BIT];
            cnt_clr = s_axi.S_AXI_WDATA[CTRL_CLR_BIT];
        end
        if (wr_en && wr_off == ADDR_KEY) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    key_d[8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
                end
            end
        end

        arready_d = s_axi.S_AXI_ARVALID & !rvalid_q & !arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            case (rd_off)
                ADDR_CTRL: rdata_d[CTRL_EN_BIT] = en_q;
                ADDR_KEY:  rdata_d = key_q;
                ADDR_HIT:  rdata_d = hit_cnt;
                ADDR_DROP: rdata_d = drop_cnt;
                default:   rdata_d = '0;
            endcase
        end else if (s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // Bus and register state; reset drops any transaction in flight
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            key_q     <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            key_q     <= key_d;
        end
    end

    sat_event_counter #(.WIDTH(CNT_W)) u_hit_cnt (
        .clk (ACLK),
        .rst (ARESET),
        .en  (en_q),
        .clr (cnt_clr),
        .inc (hit_pulse),
        .cnt (hit_cnt)
    );

    sat_event_counter #(.WIDTH(CNT_W)) u_drop_cnt (
        .clk (ACLK),
        .rst (ARESET),
        .en  (en_q),
        .clr (cnt_clr),
        .inc (drop_pulse),
        .cnt (drop_cnt)
    );

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = awready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;
    assign extract_en          = en_q;
    assign extract_key         = key_q;
endmodule

// File: tb/tb_axi_extraction_regs.sv
// tb/tb_axi_extraction_regs.sv - randomized self-checking bench for axi_extraction_regs
module tb_axi_extraction_regs;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        extract_en;
    logic [31:0] extract_key;
    logic        hit_pulse;
    logic        drop_pulse;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_en;
    logic [31:0] m_key;
    logic [31:0] m_hit;
    logic [31:0] m_drop;

    axi_extraction_regs_if bus ();

    axi_extraction_regs dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .s_axi       (bus.slave),
        .extract_en  (extract_en),
        .extract_key (extract_key),
        .hit_pulse   (hit_pulse),
        .drop_pulse  (drop_pulse)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        longint unsigned n;
        n = longint'(v) + 1;
        return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a >> 2)
            0: return {31'd0, m_en};
            1: return m_key;
            2: return m_hit;
            default: return m_drop;
        endcase
    endfunction

    function automatic logic [1:0] model_resp(input logic [3:0] a);
        return ((a >> 2) >= 2) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d,
                               input logic [3:0] s, input bit hit_same_edge);
        if (hit_same_edge && m_en) m_hit = sat_inc(m_hit);
        if ((a >> 2) == 0 && s[0]) begin
            m_en = d[0];
            if (d[1]) begin
                m_hit  = 0;
                m_drop = 0;
            end
        end else if ((a >> 2) == 1) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_key[8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_key = 0; m_hit = 0; m_drop = 0;
    endtask

    task automatic apply_reset();
        ARESET = 1'b1;
        bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_BREADY = 0;
        bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 0;
        hit_pulse = 0; drop_pulse = 0;
        repeat (2) @(posedge ACLK);
        #3 ARESET = 1'b0;
        model_reset();
        @(posedge ACLK); #1;
    endtask

    // Full write transaction; optional hit pulse on the handshake edge and BREADY stall
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit hit_hs, input int bstall,
                             output logic [1:0] resp, output bit stable);
        int n;
        logic [1:0] r0;
        stable = 1;
        bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
        bus.S_AXI_AWPROT = 3'($urandom); bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1;
        n = 0;
        @(posedge ACLK); #1;
        while (!bus.S_AXI_AWREADY && n < 20) begin @(posedge ACLK); #1; n++; end
        if (!bus.S_AXI_AWREADY) begin
            total++; bad++;
            $display("FAIL aw_ready_timeout addr=%h got=0 want=1", a);
        end
        if (hit_hs) hit_pulse = 1;
        @(posedge ACLK); #1;
        hit_pulse = 0;
        bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
        model_write(a, d, s, hit_hs);
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
        if (!bus.S_AXI_BVALID) begin
            total++; bad++;
            $display("FAIL bvalid_timeout addr=%h got=0 want=1", a);
        end
        resp = bus.S_AXI_BRESP;
        r0 = resp;
        for (int i = 0; i < bstall; i++) begin
            @(posedge ACLK); #1;
            if (!bus.S_AXI_BVALID || bus.S_AXI_BRESP !== r0) stable = 0;
        end
        bus.S_AXI_BREADY = 1;
        @(posedge ACLK); #1;
        bus.S_AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [3:0] a, input int rstall,
                            output logic [31:0] data, output bit stable);
        int n;
        stable = 1;
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARPROT = 3'($urandom); bus.S_AXI_ARVALID = 1;
        n = 0;
        @(posedge ACLK); #1;
        while (!bus.S_AXI_ARREADY && n < 20) begin @(posedge ACLK); #1; n++; end
        if (!bus.S_AXI_ARREADY) begin
            total++; bad++;
            $display("FAIL ar_ready_timeout addr=%h got=0 want=1", a);
        end
        @(posedge ACLK); #1;
        bus.S_AXI_ARVALID = 0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
        if (!bus.S_AXI_RVALID) begin
            total++; bad++;
            $display("FAIL rvalid_timeout addr=%h got=0 want=1", a);
        end
        data = bus.S_AXI_RDATA;
        for (int i = 0; i < rstall; i++) begin
            @(posedge ACLK); #1;
            if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== data || bus.S_AXI_RRESP !== 2'b00)
                stable = 0;
        end
        bus.S_AXI_RREADY = 1;
        @(posedge ACLK); #1;
        bus.S_AXI_RREADY = 0;
    endtask

    task automatic pulse_cycle(input bit h, input bit d);
        hit_pulse = h; drop_pulse = d;
        @(posedge ACLK);
        if (m_en && h) m_hit = sat_inc(m_hit);
        if (m_en && d) m_drop = sat_inc(m_drop);
        #1;
        hit_pulse = 0; drop_pulse = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bit st;
        total++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY, bus.S_AXI_RVALID} !== 4'b0) begin
            bad++;
            $display("FAIL reset_handshake got=%b want=0000",
                     {bus.S_AXI_AWREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY, bus.S_AXI_RVALID});
        end
        total++;
        if (extract_en !== 1'b0 || extract_key !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got en=%b key=%h want en=0 key=0", extract_en, extract_key);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), 0, rd, st);
            total++;
            if (rd !== 32'h0) begin
                bad++;
                $display("FAIL reset_reg%0d got=%h want=00000000", i, rd);
            end
        end
    endtask

    task automatic test_regmap();
        logic [1:0]  resp;
        logic [31:0] rd;
        bit st;
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, resp, st);
            total++;
            if (resp !== model_resp(4'(i * 4))) begin
                bad++;
                $display("FAIL regmap_bresp%0d got=%b want=%b", i, resp, model_resp(4'(i * 4)));
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), 0, rd, st);
            total++;
            if (rd !== model_read(4'(i * 4))) begin
                bad++;
                $display("FAIL regmap_read%0d got=%h want=%h", i, rd, model_read(4'(i * 4)));
            end
        end
        total++;
        if (extract_en !== 1'b1 || extract_key !== 32'h2) begin
            bad++;
            $display("FAIL regmap_outputs got en=%b key=%h want en=1 key=00000002", extract_en, extract_key);
        end
    endtask

    task automatic test_counters();
        logic [1:0]  resp;
        logic [31:0] rd;
        bit st;
        axi_write(4'h0, 32'h3, 4'hF, 0, 0, resp, st);
        for (int i = 0; i < 5; i++) pulse_cycle(1, i < 3);
        axi_read(4'h8, 0, rd, st);
        total++;
        if (rd !== m_hit || rd !== 32'd5) begin
            bad++;
            $display("FAIL cnt_hit got=%h want=%h", rd, m_hit);
        end
        axi_read(4'hC, 0, rd, st);
        total++;
        if (rd !== m_drop || rd !== 32'd3) begin
            bad++;
            $display("FAIL cnt_drop got=%h want=%h", rd, m_drop);
        end
        axi_write(4'h0, 32'h0, 4'hF, 0, 0, resp, st);
        pulse_cycle(1, 0);
        pulse_cycle(1, 0);
        axi_read(4'h8, 0, rd, st);
        total++;
        if (rd !== m_hit) begin
            bad++;
            $display("FAIL cnt_hit_disabled got=%h want=%h", rd, m_hit);
        end
    endtask

    task automatic test_clear_priority();
        logic [1:0]  resp;
        logic [31:0] rd;
        bit st;
        axi_write(4'h0, 32'h1, 4'hF, 0, 0, resp, st);
        pulse_cycle(1, 1);
        axi_write(4'h0, 32'h3, 4'hF, 1, 0, resp, st);
        axi_read(4'h8, 0, rd, st);
        total++;
        if (rd !== 32'h0 || rd !== m_hit) begin
            bad++;
            $display("FAIL clear_wins got=%h want=00000000", rd);
        end
        axi_read(4'h0, 0, rd, st);
        total++;
        if (rd !== 32'h1) begin
            bad++;
            $display("FAIL clear_selfclear got=%h want=00000001", rd);
        end
    endtask

    task automatic test_saturation();
        logic [1:0]  resp;
        logic [31:0] rd;
        bit st;
        axi_write(4'h0, 32'h1, 4'hF, 0, 0, resp, st);
        force dut.u_hit_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_hit_cnt.cnt_q;
        m_hit = 32'hFFFF_FFFE;
        repeat (3) pulse_cycle(1, 0);
        axi_read(4'h8, 0, rd, st);
        total++;
        if (rd !== 32'hFFFF_FFFF || rd !== m_hit) begin
            bad++;
            $display("FAIL saturate got=%h want=ffffffff", rd);
        end
    endtask

    task automatic test_strobe_stall();
        logic [1:0]  resp;
        logic [31:0] rd;
        bit st;
        axi_write(4'h4, 32'hAABB_CCDD, 4'hF, 0, 0, resp, st);
        axi_write(4'h4, 32'h1122_3344, 4'b0101, 0, 4, resp, st);
        total++;
        if (st !== 1'b1 || resp !== 2'b00) begin
            bad++;
            $display("FAIL bvalid_stall got stable=%0d resp=%b want stable=1 resp=00", st, resp);
        end
        axi_read(4'h4, 4, rd, st);
        total++;
        if (rd !== 32'hAA22_CC44 || rd !== m_key) begin
            bad++;
            $display("FAIL wstrb_key got=%h want=aa22cc44", rd);
        end
        total++;
        if (st !== 1'b1) begin
            bad++;
            $display("FAIL rvalid_stall got stable=%0d want=1", st);
        end
        total++;
        if (extract_key !== m_key) begin
            bad++;
            $display("FAIL key_output got=%h want=%h", extract_key, m_key);
        end
    endtask

    task automatic test_random();
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [3:0]  a;
        logic [31:0] d;
        bit st;
        for (int it = 0; it < 40; it++) begin
            a = 4'($urandom_range(0, 3) * 4);
            case ($urandom_range(0, 2))
                0: begin
                    d = $urandom;
                    if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
                    axi_write(a, d, 4'($urandom), 0, $urandom_range(0, 2), resp, st);
                    total++;
                    if (resp !== model_resp(a)) begin
                        bad++;
                        $display("FAIL rand_bresp addr=%h got=%b want=%b", a, resp, model_resp(a));
                    end
                end
                1: begin
                    for (int k = 0; k < int'($urandom_range(1, 6)); k++)
                        pulse_cycle(1'($urandom), 1'($urandom));
                end
                default: begin
                    axi_read(a, $urandom_range(0, 2), rd, st);
                    total++;
                    if (rd !== model_read(a)) begin
                        bad++;
                        $display("FAIL rand_read addr=%h got=%h want=%h", a, rd, model_read(a));
                    end
                end
            endcase
        end
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] rd;
        bit st;
        int n;
        bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'h5555_AAAA; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1; bus.S_AXI_BREADY = 0;
        n = 0;
        @(posedge ACLK); #1;
        while (!bus.S_AXI_AWREADY && n < 20) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
        total++;
        if (bus.S_AXI_BVALID !== 1'b1) begin
            bad++;
            $display("FAIL midwrite_bvalid_pre got=%b want=1", bus.S_AXI_BVALID);
        end
        #1 ARESET = 1'b1;
        #1;
        total++;
        if (bus.S_AXI_BVALID !== 1'b0 || extract_key !== 32'h0) begin
            bad++;
            $display("FAIL midwrite_async got bvalid=%b key=%h want bvalid=0 key=0",
                     bus.S_AXI_BVALID, extract_key);
        end
        @(posedge ACLK);
        #3 ARESET = 1'b0;
        model_reset();
        @(posedge ACLK); #1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), 0, rd, st);
            total++;
            if (rd !== 32'h0) begin
                bad++;
                $display("FAIL midwrite_reg%0d got=%h want=00000000", i, rd);
            end
        end
        total++;
        if (extract_en !== 1'b0 || bus.S_AXI_BVALID !== 1'b0) begin
            bad++;
            $display("FAIL midwrite_after got en=%b bvalid=%b want 0 0", extract_en, bus.S_AXI_BVALID);
        end
    endtask

    initial begin
        bus.S_AXI_AWADDR = 0; bus.S_AXI_AWPROT = 0; bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0;
        bus.S_AXI_ARADDR = 0; bus.S_AXI_ARPROT = 0;
        apply_reset();
        test_reset();
        test_regmap();
        test_counters();
        test_clear_priority();
        test_saturation();
        test_strobe_stall();
        test_random();
        test_reset_midwrite();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
